// File: rtl/zz_irq_ctl_if.sv
// PC pre-control bundle between the fetch-stage pipeline and the interrupt front end.
// The pipeline (master) supplies requests and status; the controller (slave) returns the PC control.
interface zz_irq_ctl_if #(
    parameter int NSRC = 4
);
    logic            pause;
    logic [NSRC-1:0] irq_req;
    logic            mask_we;
    logic [NSRC-1:0] mask_din;
    logic [31:0]     pc_cur;
    logic            in_dslot;
    logic            ret_i;
    logic [3:0]      pc_prectl;
    logic [31:0]     irq_addr;
    logic [31:0]     zz_spc;
    logic [2:0]      cause;
    logic            in_isr;

    modport master (
        output pause, irq_req, mask_we, mask_din, pc_cur, in_dslot, ret_i,
        input  pc_prectl, irq_addr, zz_spc, cause, in_isr
    );

    modport slave (
        input  pause, irq_req, mask_we, mask_din, pc_cur, in_dslot, ret_i,
        output pc_prectl, irq_addr, zz_spc, cause, in_isr
    );
endinterface

// File: rtl/zz_irq_ctl.sv
// Interrupt front end for the mips789 fetch stage: edge capture, masking, fixed
// priority select and one-shot PC_IRQ hand-off, with nesting blocked until return.
module zz_irq_ctl #(
    parameter int          NSRC       = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0050,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic           clock,
    input  logic           rst,
    zz_irq_ctl_if.slave    bus
);
    // PC pre-control codes shared with the next-PC generator (mips789_defs.v)
    localparam logic [3:0] PC_IGN = 4'd1;
    localparam logic [3:0] PC_IRQ = 4'd2;
    localparam logic [3:0] PC_RST = 4'd3;

    localparam logic [1:0] ST_RST  = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_TAKE = 2'd2;
    localparam logic [1:0] ST_ISR  = 2'd3;

    logic [1:0]      state_reg, state_next;
    logic [NSRC-1:0] pending_reg, pending_next;
    logic [NSRC-1:0] mask_reg;
    logic [NSRC-1:0] prev_req_reg;
    logic            gie_reg;
    logic [31:0]     spc_reg;
    logic [31:0]     addr_reg;
    logic [2:0]      cause_reg;

    logic [NSRC-1:0] hit;
    logic [NSRC-1:0] clr;
    logic [2:0]      sel_idx;
    logic            take;

    assign hit  = pending_reg & mask_reg;
    assign take = (state_reg == ST_IDLE) && (|hit) && gie_reg
                  && !bus.pause && !bus.in_dslot;

    // Scan downward so the last match, i.e. the lowest index, wins
    always_comb begin
        sel_idx = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (hit[i]) sel_idx = 3'(i);
        end
    end

    // A fresh edge on the source being taken re-arms it: set beats clear
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_pend
            assign clr[gi]          = take && (sel_idx == 3'(gi));
            assign pending_next[gi] = (pending_reg[gi] & ~clr[gi])
                                    | (bus.irq_req[gi] & ~prev_req_reg[gi]);
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RST:  state_next = ST_IDLE;
            ST_IDLE: if (take) state_next = ST_TAKE;
            ST_TAKE: if (!bus.pause) state_next = ST_ISR;
            ST_ISR:  if (bus.ret_i && !bus.pause) state_next = ST_IDLE;
            default: state_next = ST_RST;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_RST;
            pending_reg  <= '0;
            mask_reg     <= '0;
            prev_req_reg <= '0;
            gie_reg      <= 1'b1;
            spc_reg      <= 32'd0;
            addr_reg     <= VEC_BASE;
            cause_reg    <= 3'd0;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            prev_req_reg <= bus.irq_req;
            if (bus.mask_we) mask_reg <= bus.mask_din;
            if (take) begin
                spc_reg   <= bus.pc_cur;
                cause_reg <= sel_idx;
                addr_reg  <= VEC_BASE + VEC_STRIDE * {29'd0, sel_idx};
                gie_reg   <= 1'b0;
            end else if (state_reg == ST_ISR && bus.ret_i && !bus.pause) begin
                gie_reg   <= 1'b1;
            end
        end
    end

    assign bus.pc_prectl = (state_reg == ST_RST)  ? PC_RST :
                           (state_reg == ST_TAKE) ? PC_IRQ : PC_IGN;
    assign bus.in_isr    = (state_reg == ST_TAKE) || (state_reg == ST_ISR);
    assign bus.zz_spc    = spc_reg;
    assign bus.irq_addr  = addr_reg;
    assign bus.cause     = cause_reg;
endmodule

// File: tb/tb_zz_irq_ctl.sv
// Self-checking bench for zz_irq_ctl: directed scenarios plus a randomized run
// compared against a transaction-level reference model.
module tb_zz_irq_ctl;
    localparam logic [3:0] PC_IGN = 4'd1;
    localparam logic [3:0] PC_IRQ = 4'd2;
    localparam logic [3:0] PC_RST = 4'd3;

    logic clock = 1'b0;
    logic rst   = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    zz_irq_ctl_if #(.NSRC(4)) bus();

    zz_irq_ctl #(
        .NSRC(4), .VEC_BASE(32'h0000_0050), .VEC_STRIDE(32'h0000_0010)
    ) dut (
        .clock(clock),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- reference model ----------------
    // handler: 0 = reset cycle, 1 = free, 2 = vector being issued, 3 = handler running
    int          m_handler;
    logic [3:0]  m_pend, m_mask, m_prev;
    logic [31:0] m_spc, m_addr;
    logic [2:0]  m_cause;
    logic [3:0]  m_edges;
    int          m_pick;

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int k);
        logic [3:0] r = 4'd0;
        for (int i = 0; i < 4; i++) if (i == k) r[i] = 1'b1;
        return r;
    endfunction

    assign m_edges = bus.irq_req & ~m_prev;
    always_comb m_pick = lowest(m_pend & m_mask);

    always @(posedge clock or posedge rst) begin
        if (rst) begin
            m_handler <= 0;
            m_pend    <= 4'd0;
            m_mask    <= 4'd0;
            m_prev    <= 4'd0;
            m_spc     <= 32'd0;
            m_addr    <= 32'h50;
            m_cause   <= 3'd0;
        end else begin
            m_prev <= bus.irq_req;
            if (bus.mask_we) m_mask <= bus.mask_din;
            if (m_handler == 1 && m_pick >= 0 && !bus.pause && !bus.in_dslot) begin
                m_handler <= 2;
                m_spc     <= bus.pc_cur;
                m_cause   <= 3'(m_pick);
                m_addr    <= 32'h50 + 32'(m_pick) * 32'h10;
                m_pend    <= (m_pend & ~onehot(m_pick)) | m_edges;
            end else begin
                m_pend <= m_pend | m_edges;
                if (m_handler == 0) m_handler <= 1;
                else if (m_handler == 2 && !bus.pause) m_handler <= 3;
                else if (m_handler == 3 && bus.ret_i && !bus.pause) m_handler <= 1;
            end
        end
    end

    function automatic logic [3:0] m_prectl();
        return (m_handler == 0) ? PC_RST : (m_handler == 2) ? PC_IRQ : PC_IGN;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic quiet_inputs();
        bus.pause = 0; bus.irq_req = 0; bus.mask_we = 0; bus.mask_din = 0;
        bus.pc_cur = 0; bus.in_dslot = 0; bus.ret_i = 0;
    endtask

    task automatic do_reset();
        tick(); quiet_inputs(); rst = 1;
        tick(); rst = 0;
        tick();
    endtask

    task automatic write_mask(input logic [3:0] m);
        bus.mask_we = 1; bus.mask_din = m;
        tick(); bus.mask_we = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        tick(); quiet_inputs(); rst = 1; #1;
        checks++; if (bus.pc_prectl !== PC_RST) begin errors++; $display("FAIL reset_prectl got=%h exp=%h", bus.pc_prectl, PC_RST); end
        checks++; if (bus.irq_addr !== 32'h50) begin errors++; $display("FAIL reset_addr got=%h exp=%h", bus.irq_addr, 32'h50); end
        checks++; if (bus.zz_spc !== 32'h0) begin errors++; $display("FAIL reset_spc got=%h exp=0", bus.zz_spc); end
        checks++; if (bus.in_isr !== 1'b0 || bus.cause !== 3'd0) begin errors++; $display("FAIL reset_isr_cause got=%b/%0d exp=0/0", bus.in_isr, bus.cause); end
        tick(); rst = 0; #1;
        checks++; if (bus.pc_prectl !== PC_RST) begin errors++; $display("FAIL release_prectl got=%h exp=%h", bus.pc_prectl, PC_RST); end
        tick();
        checks++; if (bus.pc_prectl !== PC_IGN) begin errors++; $display("FAIL after_release got=%h exp=%h", bus.pc_prectl, PC_IGN); end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        do_reset();
        bus.pc_cur = 32'h0000_1234;
        write_mask(4'b0100);
        bus.irq_req = 4'b0100; tick(); bus.irq_req = 0;
        checks++; if (bus.pc_prectl !== PC_IGN) begin errors++; $display("FAIL basic_pre got=%h exp=%h", bus.pc_prectl, PC_IGN); end
        tick();
        checks++; if (bus.pc_prectl !== PC_IRQ) begin errors++; $display("FAIL basic_irq got=%h exp=%h", bus.pc_prectl, PC_IRQ); end
        checks++; if (bus.irq_addr !== 32'h70) begin errors++; $display("FAIL basic_addr got=%h exp=%h", bus.irq_addr, 32'h70); end
        checks++; if (bus.zz_spc !== 32'h1234) begin errors++; $display("FAIL basic_spc got=%h exp=%h", bus.zz_spc, 32'h1234); end
        checks++; if (bus.cause !== 3'd2) begin errors++; $display("FAIL basic_cause got=%0d exp=2", bus.cause); end
        tick();
        checks++; if (bus.pc_prectl !== PC_IGN || bus.in_isr !== 1'b1) begin errors++; $display("FAIL basic_isr got=%h/%b exp=%h/1", bus.pc_prectl, bus.in_isr, PC_IGN); end
        bus.ret_i = 1; tick(); bus.ret_i = 0;
        checks++; if (bus.in_isr !== 1'b0) begin errors++; $display("FAIL basic_ret got=%b exp=0", bus.in_isr); end
        $display("test_basic done");
    endtask

    task automatic test_priority();
        do_reset();
        write_mask(4'hF);
        bus.irq_req = 4'b1010; tick(); bus.irq_req = 0; tick();
        checks++; if (bus.pc_prectl !== PC_IRQ || bus.cause !== 3'd1 || bus.irq_addr !== 32'h60) begin errors++; $display("FAIL prio_first got=%h/%0d/%h exp=%h/1/60", bus.pc_prectl, bus.cause, bus.irq_addr, PC_IRQ); end
        tick();
        bus.irq_req = 4'b0001; tick(); bus.irq_req = 0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.pc_prectl !== PC_IGN || bus.in_isr !== 1'b1) begin errors++; $display("FAIL prio_nest cyc=%0d got=%h/%b exp=%h/1", i, bus.pc_prectl, bus.in_isr, PC_IGN); end
            tick();
        end
        bus.ret_i = 1; tick(); bus.ret_i = 0;
        checks++; if (bus.in_isr !== 1'b0) begin errors++; $display("FAIL prio_ret got=%b exp=0", bus.in_isr); end
        tick();
        checks++; if (bus.pc_prectl !== PC_IRQ || bus.irq_addr !== 32'h50 || bus.cause !== 3'd0) begin errors++; $display("FAIL prio_src0 got=%h/%h/%0d exp=%h/50/0", bus.pc_prectl, bus.irq_addr, bus.cause, PC_IRQ); end
        tick(); bus.ret_i = 1; tick(); bus.ret_i = 0; tick();
        checks++; if (bus.pc_prectl !== PC_IRQ || bus.irq_addr !== 32'h80 || bus.cause !== 3'd3) begin errors++; $display("FAIL prio_src3 got=%h/%h/%0d exp=%h/80/3", bus.pc_prectl, bus.irq_addr, bus.cause, PC_IRQ); end
        $display("test_priority done");
    endtask

    task automatic test_masking();
        do_reset();
        bus.irq_req = 4'b0100; tick(); bus.irq_req = 0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.pc_prectl !== PC_IGN) begin errors++; $display("FAIL mask_hold cyc=%0d got=%h exp=%h", i, bus.pc_prectl, PC_IGN); end
            tick();
        end
        write_mask(4'b0100);
        checks++; if (bus.pc_prectl !== PC_IGN) begin errors++; $display("FAIL mask_write got=%h exp=%h", bus.pc_prectl, PC_IGN); end
        tick();
        checks++; if (bus.pc_prectl !== PC_IRQ || bus.irq_addr !== 32'h70) begin errors++; $display("FAIL mask_take got=%h/%h exp=%h/70", bus.pc_prectl, bus.irq_addr, PC_IRQ); end
        $display("test_masking done");
    endtask

    task automatic test_stall();
        do_reset();
        write_mask(4'hF);
        bus.in_dslot = 1; bus.pc_cur = 32'hA0;
        bus.irq_req = 4'b0010; tick(); bus.irq_req = 0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.pc_prectl !== PC_IGN) begin errors++; $display("FAIL dslot cyc=%0d got=%h exp=%h", i, bus.pc_prectl, PC_IGN); end
            tick();
        end
        bus.in_dslot = 0; tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.pc_prectl !== PC_IRQ || bus.zz_spc !== 32'hA0) begin errors++; $display("FAIL pause_take cyc=%0d got=%h/%h exp=%h/a0", i, bus.pc_prectl, bus.zz_spc, PC_IRQ); end
            bus.pause = (i < 2); bus.pc_cur = 32'hBEEF;
            tick();
        end
        checks++; if (bus.pc_prectl !== PC_IGN || bus.in_isr !== 1'b1) begin errors++; $display("FAIL pause_isr got=%h/%b exp=%h/1", bus.pc_prectl, bus.in_isr, PC_IGN); end
        $display("test_stall done");
    endtask

    task automatic test_async_reset();
        do_reset();
        write_mask(4'hF);
        bus.irq_req = 4'b0100; tick(); bus.irq_req = 0; tick(); tick();
        bus.irq_req = 4'b0001; tick(); bus.irq_req = 0;
        #2 rst = 1; #1;
        checks++; if (bus.pc_prectl !== PC_RST || bus.in_isr !== 1'b0) begin errors++; $display("FAIL arst_now got=%h/%b exp=%h/0", bus.pc_prectl, bus.in_isr, PC_RST); end
        tick(); rst = 0; tick();
        bus.irq_req = 4'b1000; tick(); bus.irq_req = 0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.pc_prectl !== PC_IGN) begin errors++; $display("FAIL arst_mask cyc=%0d got=%h exp=%h", i, bus.pc_prectl, PC_IGN); end
            tick();
        end
        write_mask(4'hF); tick();
        checks++; if (bus.pc_prectl !== PC_IRQ || bus.cause !== 3'd3) begin errors++; $display("FAIL arst_pend got=%h/%0d exp=%h/3", bus.pc_prectl, bus.cause, PC_IRQ); end
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            checks++;
            if (bus.pc_prectl !== m_prectl() || bus.in_isr !== (m_handler >= 2) ||
                bus.irq_addr !== m_addr || bus.zz_spc !== m_spc || bus.cause !== m_cause) begin
                errors++;
                $display("FAIL rnd cyc=%0d got=%h/%b/%h/%h/%0d exp=%h/%b/%h/%h/%0d", c,
                         bus.pc_prectl, bus.in_isr, bus.irq_addr, bus.zz_spc, bus.cause,
                         m_prectl(), (m_handler >= 2), m_addr, m_spc, m_cause);
            end
            bus.irq_req  = ($urandom_range(0, 9) < 3) ? 4'($urandom_range(0, 15)) : 4'd0;
            bus.pause    = ($urandom_range(0, 9) < 2);
            bus.in_dslot = ($urandom_range(0, 9) < 2);
            bus.ret_i    = ($urandom_range(0, 9) < 3);
            bus.mask_we  = ($urandom_range(0, 9) < 1);
            bus.mask_din = 4'($urandom_range(0, 15));
            bus.pc_cur   = $urandom;
            tick();
        end
        $display("test_random done");
    endtask

    initial begin
        quiet_inputs();
        test_reset();
        test_basic();
        test_priority();
        test_masking();
        test_stall();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/zz_irq_ctl.md
Name: zz_irq_ctl

Overview:
- Interrupt/exception front end for the mips789 fetch stage. It is the producer side of the PC pre-control interface that the next-PC generator consumes.
- Latches external interrupt edges, applies a mask and a global enable, and picks the highest-priority source.
- Drives the 4-bit PC pre-control code, the interrupt vector and the saved return PC (zz_spc).
- Blocks nesting until the handler's return instruction is executed.

Parameters:
- NSRC, 4, number of interrupt sources, 1..8.
- VEC_BASE, 32'h0000_0050, vector of source 0.
- VEC_STRIDE, 32'h0000_0010, byte distance between consecutive source vectors.

Ports:
- clock  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pause  in  1  pipeline stall; when 1, state, zz_spc, irq_addr and cause hold.
- irq_req  in  NSRC  raw interrupt lines, level, synchronous to clock.
- mask_we  in  1  mask register write strobe.
- mask_din  in  NSRC  new mask value; 1 = source enabled.
- pc_cur  in  32  PC of the instruction that will be resumed.
- in_dslot  in  1  1 = pc_cur is a branch delay slot; the interrupt is deferred.
- ret_i  in  1  handler-return instruction executed (PC_RET issued).
- pc_prectl  out  4  `PC_RST / `PC_IRQ / `PC_IGN code (mips789_defs.v).
- irq_addr  out  32  vector for `PC_IRQ.
- zz_spc  out  32  saved return PC for `PC_RET.
- cause  out  3  index of the source taken.
- in_isr  out  1  1 while the handler is active (TAKE or ISR).

Behaviour:
- Reset (async, any time, including mid-TAKE or mid-ISR):
  - state=RST; pending=0; mask=0; gie=1; zz_spc=0; irq_addr=VEC_BASE; cause=0; prev_req=0.
  - pc_prectl=`PC_RST while rst=1.
- States:
  - RST -> IDLE on the first clock edge after rst falls. pc_prectl=`PC_RST in RST, so the fetch stage gets exactly one reset cycle after release.
  - IDLE: pc_prectl=`PC_IGN. Go to TAKE when (pending & mask)!=0, gie=1, pause=0 and in_dslot=0.
  - On the IDLE->TAKE edge:
    - zz_spc<=pc_cur.
    - cause<=lowest set index k of (pending & mask); lowest index = highest priority.
    - irq_addr<=VEC_BASE+k*VEC_STRIDE (32-bit, modulo 2^32).
    - pending[k]<=0.
    - gie<=0.
  - TAKE: pc_prectl=`PC_IRQ for exactly one cycle. Stays in TAKE while pause=1, and pc_prectl remains `PC_IRQ. Go to ISR when pause=0.
  - ISR: pc_prectl=`PC_IGN. When ret_i=1 and pause=0: go to IDLE and gie<=1. New interrupts are only latched in pending, not taken.
- in_isr=1 in TAKE and ISR, else 0.
- Edge capture: prev_req<=irq_req every cycle, regardless of pause. pending[i] is set when irq_req[i]&~prev_req[i], independent of mask and state.
  - If a new edge arrives in the same cycle pending[i] is being cleared, set wins.
  - A level held high produces one pending event.
- Mask: when mask_we=1, mask<=mask_din on the edge, independent of pause. The new mask is used for the decision in the next cycle.
- Masked sources stay pending and are taken once unmasked.
- ret_i in IDLE or TAKE is ignored.
- pause=1 in IDLE blocks the decision. pending still accumulates.
- in_dslot=1 defers the decision until in_dslot=0. No lost requests.
- Outputs zz_spc, irq_addr and cause are registered. pc_prectl and in_isr decode combinationally from the state register only.

Test Plan:
- Reset release: rst 1->0 -> pc_prectl=`PC_RST for one cycle, then `PC_IGN; irq_addr=32'h50, zz_spc=0.
- Basic take: mask=4'b0100, pulse irq_req[2], pc_cur=32'h0000_1234 -> next cycle pc_prectl=`PC_IRQ for 1 cycle, irq_addr=32'h70, zz_spc=32'h1234, cause=2; then ISR with in_isr=1.
- Priority and nesting: mask=4'hF, edges on [3] and [1] in the same cycle -> cause=1, addr 32'h60.
  - Another [0] edge during ISR is not taken.
  - ret_i -> IDLE; next cycle source 0 is taken (addr 32'h50), then source 3 after its ret_i.
- Masking: edge on [2] with mask=0 -> no take. Writing mask=4'b0100 later -> taken one cycle after the write.
- Stall/delay slot: request pending with in_dslot=1 for 3 cycles -> no take until in_dslot drops. pause=1 in TAKE for 2 cycles -> `PC_IRQ held 3 cycles and zz_spc unchanged.
- Async reset mid-ISR: assert rst between edges -> pc_prectl=`PC_RST immediately, in_isr=0, pending cleared, mask=0.
